// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between NoC requesters and the round-robin RAM port arbiter.
// master = requester side plus RAM sequencer (req, done); slave = arbiter.
interface noc_rr_arbiter_if #(
  parameter int NUM_PORTS = 6,
  parameter int IDX_MSB   = 2
);
  logic [NUM_PORTS-1:0] req;
  logic                 done;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [IDX_MSB:0]     grant_idx;
  logic                 grant_start;
  logic                 timeout;

  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx, grant_start, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx, grant_start, timeout
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter for the shared NoC RAM port: one registered one-hot grant per
// transaction, rotating priority, back-to-back handover and a hold timeout.
module noc_rr_arbiter #(
  parameter int NUM_PORTS = 6,
  parameter int IDX_MSB   = 2,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_MSB   = 4
) (
  input logic              clk,
  input logic              rst,
  noc_rr_arbiter_if.slave  bus
);
  localparam int IDX_W = IDX_MSB + 1;
  localparam int CNT_W = CNT_MSB + 1;
  localparam int PAD_W = 1 << IDX_W;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic [IDX_MSB:0]     ptr_q;
  logic [IDX_MSB:0]     idx_q;
  logic [CNT_MSB:0]     cnt_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic                 grant_valid_q;
  logic                 grant_start_q;
  logic                 timeout_q;

  logic                 hold_expired;
  logic                 grant_end;
  logic [IDX_MSB:0]     idx_inc;
  logic [IDX_MSB:0]     base_d;
  logic [IDX_MSB:0]     win_idx_d;
  logic [NUM_PORTS-1:0] win_onehot_d;
  logic                 any_req_d;
  logic [PAD_W-1:0]     req_pad;
  int                   cand;
  logic [IDX_MSB:0]     cand_idx;

  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  assign grant_end    = (state_q == BUSY) && (bus.done || hold_expired);
  assign idx_inc      = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
  // When a grant ends this cycle, the search already starts past the winner.
  assign base_d       = grant_end ? idx_inc : ptr_q;
  assign req_pad      = PAD_W'(bus.req);

  // Scan from the farthest offset down so the nearest requester overwrites the result.
  always_comb begin
    win_idx_d = base_d;
    any_req_d = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      cand = int'(base_d) + off;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (req_pad[cand_idx]) begin
        win_idx_d = cand_idx;
        any_req_d = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
    assign win_onehot_d[gi] = (win_idx_d == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      grant_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q       <= BUSY;
            grant_q       <= win_onehot_d;
            grant_valid_q <= 1'b1;
            idx_q         <= win_idx_d;
            grant_start_q <= 1'b1;
            cnt_q         <= '0;
          end
        end
        BUSY: begin
          if (grant_end) begin
            ptr_q     <= base_d;
            timeout_q <= !bus.done;
            if (any_req_d) begin
              grant_q       <= win_onehot_d;
              idx_q         <= win_idx_d;
              grant_start_q <= 1'b1;
              cnt_q         <= '0;
            end else begin
              state_q       <= IDLE;
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_start = grant_start_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Scenario bench for noc_rr_arbiter: expected grant indices are queued when requests
// are driven and popped when the arbiter raises grant_start.
module tb_noc_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  noc_rr_arbiter_if #(.NUM_PORTS(6), .IDX_MSB(2)) bus_if ();

  noc_rr_arbiter #(.NUM_PORTS(6), .IDX_MSB(2), .MAX_HOLD(16), .CNT_MSB(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_if.req = '0; bus_if.done = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus_if.grant, bus_if.grant_valid, bus_if.grant_idx, bus_if.grant_start, bus_if.timeout} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b valid=%b idx=%0d start=%b timeout=%b, want all 0",
               bus_if.grant, bus_if.grant_valid, bus_if.grant_idx, bus_if.grant_start, bus_if.timeout);
    end
    rst = 1'b0;
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    int e;
    bus_if.req = 6'b000100; exp_q.push_back(2);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_start !== 1'b1 || bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e) || bus_if.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got start=%b idx=%0d grant=%b, want start=1 idx=%0d", bus_if.grant_start, bus_if.grant_idx, bus_if.grant, e);
    end
    bus_if.req = '0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (bus_if.grant !== 6'b000100 || bus_if.grant_start !== 1'b0) begin
        errors++;
        $display("FAIL single_hold cycle %0d: got grant=%b start=%b, want grant=000100 start=0", c, bus_if.grant, bus_if.grant_start);
      end
      if (c == 4) bus_if.done = 1'b1;
    end
    tick();
    bus_if.done = 1'b0;
    checks++;
    if (bus_if.grant !== 6'b0 || bus_if.grant_valid !== 1'b0 || bus_if.grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL single_release: got grant=%b valid=%b idx=%0d, want grant=0 valid=0 idx=2", bus_if.grant, bus_if.grant_valid, bus_if.grant_idx);
    end
    // ptr should now be 3: ports 0 and 3 compete and 3 must win
    bus_if.req = 6'b001001; exp_q.push_back(3);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_start !== 1'b1 || bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e)) begin
      errors++;
      $display("FAIL single_ptr3: got start=%b idx=%0d grant=%b, want idx=%0d", bus_if.grant_start, bus_if.grant_idx, bus_if.grant, e);
    end
    bus_if.req = '0; bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    $display("single: grant port2 held 4 cycles, then port3 from ptr=3");
  endtask

  task automatic test_back_to_back();
    int e;
    rst = 1'b1; tick(); rst = 1'b0;
    bus_if.req = 6'b111111; bus_if.done = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(k % 6);
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      if (bus_if.grant_start !== 1'b1 || bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e) || bus_if.grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq step %0d: got start=%b idx=%0d grant=%b, want start=1 idx=%0d", k, bus_if.grant_start, bus_if.grant_idx, bus_if.grant, e);
      end
    end
    bus_if.req = '0;
    tick();
    bus_if.done = 1'b0;
    checks++;
    if (bus_if.grant_valid !== 1'b0 || bus_if.grant !== 6'b0) begin
      errors++;
      $display("FAIL rr_idle: got valid=%b grant=%b, want 0", bus_if.grant_valid, bus_if.grant);
    end
    $display("back_to_back: sequence 0..5,0 with no bubbles");
  endtask

  task automatic test_wrap();
    int e;
    bus_if.req = 6'b010000; exp_q.push_back(4);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL wrap_prep: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = '0; bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    bus_if.req = 6'b100001; exp_q.push_back(5); exp_q.push_back(0);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL wrap_first: got idx=%0d grant=%b, want idx=%0d", bus_if.grant_idx, bus_if.grant, e);
    end
    bus_if.req = 6'b000001; bus_if.done = 1'b1;
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL wrap_second: got idx=%0d grant=%b start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant, bus_if.grant_start, e);
    end
    bus_if.req = '0;
    tick();
    bus_if.done = 1'b0;
    $display("wrap: ptr=5 serves port5 then port0");
  endtask

  task automatic test_timeout();
    int e;
    bus_if.req = 6'b000010; exp_q.push_back(1);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL to_grant: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = '0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      checks++;
      if (bus_if.grant !== 6'b000010 || bus_if.timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cycle %0d: got grant=%b timeout=%b, want grant=000010 timeout=0", c, bus_if.grant, bus_if.timeout);
      end
    end
    tick();
    checks++;
    if (bus_if.grant !== 6'b0 || bus_if.grant_valid !== 1'b0 || bus_if.timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: got grant=%b valid=%b timeout=%b, want grant=0 valid=0 timeout=1", bus_if.grant, bus_if.grant_valid, bus_if.timeout);
    end
    bus_if.req = 6'b000011; exp_q.push_back(0);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1 || bus_if.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_next: got idx=%0d start=%b timeout=%b, want idx=%0d start=1 timeout=0", bus_if.grant_idx, bus_if.grant_start, bus_if.timeout, e);
    end
    bus_if.req = 6'b000010; bus_if.done = 1'b1; exp_q.push_back(1);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL to_after: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = '0;
    tick();
    bus_if.done = 1'b0;
    $display("timeout: port1 held 16 cycles, timeout pulse, port0 next");
  endtask

  task automatic test_done_vs_timeout();
    int e;
    bus_if.req = 6'b101000; exp_q.push_back(3);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL dvt_grant: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = 6'b100000;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (c == 16) begin
        bus_if.done = 1'b1;
        exp_q.push_back(5);
      end
    end
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1 || bus_if.timeout !== 1'b0) begin
      errors++;
      $display("FAIL dvt_handover: got idx=%0d start=%b timeout=%b, want idx=%0d start=1 timeout=0", bus_if.grant_idx, bus_if.grant_start, bus_if.timeout, e);
    end
    bus_if.req = '0;
    tick();
    bus_if.done = 1'b0;
    checks++;
    if (bus_if.grant_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
      errors++;
      $display("FAIL dvt_idle: got valid=%b timeout=%b, want 0 0", bus_if.grant_valid, bus_if.timeout);
    end
    $display("done_vs_timeout: done wins on hold cycle 16");
  endtask

  task automatic test_reset_mid_grant();
    int e;
    bus_if.req = 6'b000010; exp_q.push_back(1);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e)) begin
      errors++;
      $display("FAIL rst_prep: got idx=%0d, want %0d", bus_if.grant_idx, e);
    end
    bus_if.req = '0; bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    bus_if.req = 6'b001000; exp_q.push_back(3);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_grant3: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = '0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus_if.grant, bus_if.grant_valid, bus_if.grant_idx, bus_if.grant_start, bus_if.timeout} !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid: got grant=%b valid=%b idx=%0d start=%b timeout=%b, want all 0",
               bus_if.grant, bus_if.grant_valid, bus_if.grant_idx, bus_if.grant_start, bus_if.timeout);
    end
    rst = 1'b0;
    bus_if.req = 6'b001001; exp_q.push_back(0);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant !== 6'(1 << e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_ptr0: got idx=%0d grant=%b, want idx=%0d", bus_if.grant_idx, bus_if.grant, e);
    end
    bus_if.req = 6'b001000; bus_if.done = 1'b1; exp_q.push_back(3);
    tick();
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    if (bus_if.grant_idx !== 3'(e) || bus_if.grant_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got idx=%0d start=%b, want idx=%0d start=1", bus_if.grant_idx, bus_if.grant_start, e);
    end
    bus_if.req = '0;
    tick();
    bus_if.done = 1'b0;
    $display("reset_mid_grant: grant dropped, ptr back to 0");
  endtask

  initial begin
    bus_if.req  = '0;
    bus_if.done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_grant();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
